// File: rtl/atomic_counter_pkg.sv
// Shared constants for the atomic 2-word event counter.
// The counter is read over a half-width bus, so the counter is exactly two bus words wide.
package atomic_counter_pkg;

   localparam int CNT_W_DEF  = 64;
   localparam int DATA_W_DEF = 32;

   // Read kinds, decoded from atomic_i while req_i=1.
   typedef enum logic {
      RD_HI_SNAP = 1'b0,
      RD_LO_ATOM = 1'b1
   } rd_kind_e;

endpackage

// File: rtl/event_counter.sv
// Free-running wrap-around event counter with increment enable.
// The counter clears asynchronously on reset.
module event_counter #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc_en,
   output logic [W-1:0] cnt
);

   // Wraps from all-ones to zero by natural overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       cnt <= '0;
      else if (inc_en) cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/atomic_counter.sv
// Event counter read as two DATA_W halves. An atomic read returns the low half
// and freezes the high half in a snapshot, which a later plain read returns.
module atomic_counter
   import atomic_counter_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trig_i,
   input  logic              req_i,
   input  logic              atomic_i,
   output logic              ack_o,
   output logic [DATA_W-1:0] count_o
);

   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] snap_q;
   logic [DATA_W-1:0] rd_d;
   rd_kind_e          rd_kind;

   event_counter #(.W(CNT_W)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc_en (trig_i),
      .cnt    (cnt)
   );

   assign rd_kind = rd_kind_e'(atomic_i);

   // Read data is taken from the pre-increment counter, so trig_i never stalls.
   always_comb begin
      rd_d = '0;
      if (req_i) begin
         if (rd_kind == RD_LO_ATOM) rd_d = cnt[DATA_W-1:0];
         else                       rd_d = snap_q;
      end
   end

   // count_o is forced to zero in any cycle without an acknowledge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_q  <= '0;
         ack_o   <= 1'b0;
         count_o <= '0;
      end else begin
         ack_o   <= req_i;
         count_o <= rd_d;
         if (req_i && rd_kind == RD_LO_ATOM)
            snap_q <= cnt[CNT_W-1:DATA_W];
      end
   end

endmodule

// File: tb/tb_atomic_counter.sv
// Randomized and directed check of atomic_counter against a simple arithmetic model.
// A narrow instance (12-bit counter, 6-bit bus) keeps the carry and wrap cases within reach.
module tb_atomic_counter;

   localparam int DW = 6;
   localparam int CW = 2 * DW;
   localparam int CMASK = (1 << CW) - 1;
   localparam int DMASK = (1 << DW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          trig_i = 1'b0;
   logic          req_i = 1'b0;
   logic          atomic_i = 1'b0;
   logic          ack_o;
   logic [DW-1:0] count_o;

   int n_chk = 0;
   int n_err = 0;

   // Model: counter value, snapshot of high half, expected outputs.
   int m_cnt  = 0;
   int m_snap = 0;
   int exp_ack, exp_dat;

   atomic_counter #(.CNT_W(CW), .DATA_W(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .trig_i   (trig_i),
      .req_i    (req_i),
      .atomic_i (atomic_i),
      .ack_o    (ack_o),
      .count_o  (count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: drive, let one rising edge pass, then check at the next negedge.
   task automatic step(input logic t, input logic r, input logic a, input string tag);
      trig_i = t; req_i = r; atomic_i = a;
      @(posedge clk);
      if (r) begin
         exp_ack = 1;
         if (a) begin
            exp_dat = m_cnt % (1 << DW);
            m_snap  = m_cnt / (1 << DW);
         end else begin
            exp_dat = m_snap;
         end
      end else begin
         exp_ack = 0;
         exp_dat = 0;
      end
      m_cnt = (m_cnt + (t ? 1 : 0)) % (1 << CW);
      @(negedge clk);
      chk({tag, ".ack"}, 64'(ack_o), 64'(exp_ack));
      chk({tag, ".dat"}, 64'(count_o), 64'(exp_dat));
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst.ack", 64'(ack_o), 64'd0);
      chk("rst.dat", 64'(count_o), 64'd0);
      reset = 1'b0;

      // Plain read straight after reset returns zero
      step(0, 1, 0, "r030");
      chk("r030.const", 64'(count_o), 64'd0);

      // Five events then an atomic read
      repeat (5) step(1, 0, 0, "r027.trig");
      step(0, 1, 1, "r027");
      chk("r027.const", 64'(count_o), 64'd5);

      // Atomic read with a same-cycle event sees the old value
      repeat (2) step(1, 0, 0, "r029.trig");
      step(1, 1, 1, "r029");
      chk("r029.const", 64'(count_o), 64'd7);
      step(0, 1, 1, "r029.after");
      chk("r029.after.const", 64'(count_o), 64'd8);

      // Count to low-half all-ones with high half = 1, then split read across a carry
      while (m_cnt != ((1 << DW) | DMASK)) step(1, 0, 0, "r028.trig");
      step(0, 1, 1, "r028.lo");
      chk("r028.lo.const", 64'(count_o), 64'(DMASK));
      step(1, 1, 0, "r028.hi");
      chk("r028.hi.const", 64'(count_o), 64'd1);

      // Back-to-back requests
      step(0, 1, 1, "r031.a");
      step(1, 1, 0, "r031.b");
      step(0, 1, 1, "r031.c");
      step(0, 0, 0, "r031.idle");

      // Full-range wrap to zero
      while (m_cnt != CMASK) step(1, 0, 0, "wrap.trig");
      step(0, 1, 1, "wrap.top");
      chk("wrap.top.const", 64'(count_o), 64'(DMASK));
      step(1, 0, 0, "wrap.inc");
      step(0, 1, 1, "wrap.lo");
      chk("wrap.lo.const", 64'(count_o), 64'd0);
      step(0, 1, 0, "wrap.hi");
      chk("wrap.hi.const", 64'(count_o), 64'd0);

      // Random traffic
      for (int i = 0; i < 500; i++)
         step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) != 0),
              logic'($urandom_range(0, 1)), "rand");

      // Reset while an acknowledge is on the bus
      while (m_cnt < 3) step(1, 0, 0, "r032.trig");
      trig_i = 1'b0; req_i = 1'b1; atomic_i = 1'b1;
      @(posedge clk);
      #1;
      chk("r032.pre.ack", 64'(ack_o), 64'd1);
      req_i = 1'b0;
      reset = 1'b1;
      #1;
      chk("r032.ack", 64'(ack_o), 64'd0);
      chk("r032.dat", 64'(count_o), 64'd0);
      m_cnt = 0; m_snap = 0;
      @(negedge clk);
      reset = 1'b0;
      step(0, 0, 0, "r032.post0");
      step(0, 0, 0, "r032.post1");
      step(0, 1, 0, "r032.snap");
      step(0, 1, 1, "r032.cnt");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   // Hard bound so the run always ends.
   initial begin
      #2000000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/atomic_counter.md
ATOMIC_COUNTER -- requirements
Module: atomic_counter

Interface
REQ-001 Parameter CNT_W, default 64, internal event-counter width.
REQ-002 Parameter DATA_W, default 32, read-data bus width; CNT_W SHALL equal 2*DATA_W.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 trig_i  input  1  count event; +1 per cycle sampled high.
REQ-006 req_i  input  1  read request, sampled each cycle.
REQ-007 atomic_i  input  1  qualifies req_i: 1 = read low half and snapshot high half; 0 = read snapshotted high half.
REQ-008 ack_o  output  1  read-data-valid strobe.
REQ-009 count_o  output  DATA_W  read data; valid only while ack_o=1.

Function
REQ-010 The block SHALL hold a CNT_W-bit counter; trig_i=1 at a rising edge SHALL add 1.
REQ-011 The counter SHALL wrap from 2^CNT_W-1 to 0 with no flag or stall.
REQ-012 A read request SHALL be any cycle with req_i=1; atomic_i is ignored when req_i=0.
REQ-013 For req_i=1 with atomic_i=1, the block SHALL capture counter[DATA_W-1:0] as read data and load counter[CNT_W-1:DATA_W] into a DATA_W-bit snapshot register, both in that edge.
REQ-014 Captured values SHALL be the counter value before any same-cycle trig_i increment.
REQ-015 For req_i=1 with atomic_i=0, read data SHALL be the current snapshot register contents; the snapshot SHALL NOT change.
REQ-016 A non-atomic read with no preceding atomic read since reset SHALL return 0.
REQ-017 ack_o SHALL assert exactly one cycle after each request cycle, for one cycle, with count_o carrying that request's data.
REQ-018 Requests on consecutive cycles SHALL each be acknowledged (full throughput, latency 1); ack_o then stays high continuously.
REQ-019 count_o SHALL be 0 whenever ack_o=0.
REQ-020 Counting SHALL never stall during reads; trig_i and req_i in the same cycle are both honoured.
REQ-021 A new atomic read SHALL overwrite the snapshot; the last atomic read wins.

Reset
REQ-022 While reset=1, counter, snapshot, ack_o and count_o SHALL be 0, asynchronously.
REQ-023 A request in flight at reset assertion SHALL be discarded; no ack_o SHALL follow reset release for it.
REQ-024 The first rising edge after reset deasserts SHALL process trig_i and req_i normally.

Structure
REQ-025 Package atomic_counter_pkg SHALL hold CNT_W and DATA_W default constants.
REQ-026 Sub-module event_counter (parameterised width, increment enable, async reset) SHALL implement the counter; read/snapshot/ack logic SHALL live in the top.

Verification
REQ-027 Reset, then 5 trig_i pulses, then req_i=1/atomic_i=1 -> next cycle ack_o=1, count_o=5.
REQ-028 Preload by counting to 0x0000_0001_FFFF_FFFF; atomic read -> count_o=0xFFFF_FFFF; non-atomic read next cycle with trig_i=1 -> count_o=0x0000_0001.
REQ-029 Atomic read and trig_i=1 in same cycle at count 7 -> count_o=7; counter reads 8 afterwards.
REQ-030 Non-atomic read right after reset -> ack_o=1, count_o=0.
REQ-031 req_i high 3 consecutive cycles -> ack_o high 3 consecutive cycles, one cycle later, each with correct data.
REQ-032 Assert reset in the cycle after a request -> ack_o and count_o go 0 immediately; no ack after release.
